// File: rtl/sram_serial_burst_ctrl.sv
// Serial-to-SRAM bridge: shifts LSB-first frames in on SI and performs single or
// burst writes into a synchronous SRAM, or burst reads that are shifted back out on SO.
module sram_serial_burst_ctrl #(
    parameter int DW = 8,
    parameter int AW = 9,
    parameter int CW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          BGN,
    input  logic          SI,
    input  logic          LOAD_N,
    input  logic [1:0]    CTRL,
    input  logic [DW-1:0] PI,
    output logic          RDY,
    output logic          D_WE,
    output logic          CEN,
    output logic          SO,
    output logic [AW-1:0] A,
    output logic [DW-1:0] PO
);

    localparam int SW  = (DW > CW) ? (AW + DW) : (CW + AW);
    localparam int BCW = $clog2(SW + 1);

    typedef enum logic [2:0] {
        IDLE, HDR, WDATA, WRITE, RREQ, RCAP, RSHIFT, DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    state_t         w_hdrTarget;
    logic           r_burst;
    logic           r_read;
    logic [BCW-1:0] r_bitcnt;
    logic [CW:0]    r_words;
    logic [SW-1:0]  r_sh;
    logic [DW-1:0]  r_rd;
    logic           r_so;
    logic [AW-1:0]  r_a;
    logic [DW-1:0]  r_po;

    logic           w_burst;
    logic           w_read;
    logic [BCW-1:0] w_cnt;
    logic [BCW-1:0] w_cntInc;
    logic [BCW-1:0] w_hdrLen;
    logic [SW-1:0]  w_shNext;
    logic           w_lastBit;
    logic           w_wordDone;
    logic           w_shifting;
    logic [CW-1:0]  w_field;
    logic [CW:0]    w_count;
    logic           w_unused;

    assign w_unused = CTRL[1];

    // Mode comes straight from the pins on the frame-start edge, from the latches afterwards.
    assign w_burst    = (r_state == IDLE) ? CTRL[0] : r_burst;
    assign w_read     = (r_state == IDLE) ? LOAD_N  : r_read;
    assign w_cnt      = (r_state == IDLE) ? '0 : r_bitcnt;
    assign w_cntInc   = w_cnt + 1'b1;
    assign w_hdrLen   = w_burst ? BCW'(CW + AW) : (w_read ? BCW'(AW) : BCW'(AW + DW));
    assign w_lastBit  = (w_cntInc == w_hdrLen);
    assign w_wordDone = (w_cntInc == BCW'(DW));
    assign w_shifting = (r_state == WDATA) || ((r_state == WRITE) && (r_words != '0));
    assign w_field    = w_shNext[AW +: CW];
    assign w_count    = (w_field == '0) ? {1'b1, {CW{1'b0}}} : {1'b0, w_field};

    assign SO = r_so;
    assign A  = r_a;
    assign PO = r_po;

    always_comb begin
        w_shNext = r_sh;
        for (int i = 0; i < SW; i++) begin
            if (w_cnt == BCW'(i)) begin
                w_shNext[i] = SI;
            end
        end
    end

    always_comb begin
        w_hdrTarget = IDLE;
        if (w_read) begin
            w_hdrTarget = RREQ;
        end else if (w_burst) begin
            w_hdrTarget = WDATA;
        end else begin
            w_hdrTarget = WRITE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        RDY    = 1'b0;
        CEN    = 1'b1;
        D_WE   = 1'b1;
        case (r_state)
            IDLE: begin
                if (BGN) begin
                    w_next = w_lastBit ? w_hdrTarget : HDR;
                end
            end
            HDR: begin
                if (!BGN) begin
                    w_next = IDLE;
                end else if (w_lastBit) begin
                    w_next = w_hdrTarget;
                end
            end
            WDATA: begin
                if (!BGN) begin
                    w_next = IDLE;
                end else if (w_wordDone) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                CEN  = 1'b0;
                D_WE = 1'b0;
                if (!BGN) begin
                    w_next = IDLE;
                end else if (r_words == '0) begin
                    w_next = DONE;
                end else if (!w_wordDone) begin
                    w_next = WDATA;
                end
            end
            RREQ: begin
                CEN    = 1'b0;
                w_next = BGN ? RCAP : IDLE;
            end
            RCAP: begin
                w_next = BGN ? RSHIFT : IDLE;
            end
            RSHIFT: begin
                if (!BGN) begin
                    w_next = IDLE;
                end else if (r_bitcnt == BCW'(DW)) begin
                    w_next = (r_words == '0) ? DONE : RREQ;
                end
            end
            DONE: begin
                RDY = 1'b1;
                if (!BGN) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: header/data shifting, SRAM address and data, read-back serialiser.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_burst  <= 1'b0;
            r_read   <= 1'b0;
            r_bitcnt <= '0;
            r_words  <= '0;
            r_sh     <= '0;
            r_rd     <= '0;
            r_so     <= 1'b0;
            r_a      <= '0;
            r_po     <= '0;
        end else begin
            case (r_state)
                IDLE, HDR: begin
                    if (BGN) begin
                        r_sh     <= w_shNext;
                        r_bitcnt <= w_cntInc;
                        if (r_state == IDLE) begin
                            r_burst <= CTRL[0];
                            r_read  <= LOAD_N;
                        end
                        if (w_lastBit) begin
                            r_bitcnt <= '0;
                            if (w_burst) begin
                                r_a     <= w_shNext[AW-1:0];
                                r_words <= w_count;
                            end else if (w_read) begin
                                r_a     <= w_shNext[AW-1:0];
                                r_words <= (CW+1)'(1);
                            end else begin
                                r_a     <= w_shNext[DW +: AW];
                                r_po    <= w_shNext[DW-1:0];
                                r_words <= '0;
                            end
                        end
                    end
                end
                WDATA, WRITE: begin
                    if ((r_state == WRITE) && (r_words != '0)) begin
                        r_a <= r_a + 1'b1;
                    end
                    if (w_shifting) begin
                        r_sh <= w_shNext;
                        if (w_wordDone) begin
                            r_bitcnt <= '0;
                            r_po     <= w_shNext[DW-1:0];
                            r_words  <= r_words - 1'b1;
                        end else begin
                            r_bitcnt <= w_cntInc;
                        end
                    end
                end
                RCAP: begin
                    r_rd     <= PI >> 1;
                    r_so     <= PI[0];
                    r_bitcnt <= BCW'(1);
                    r_words  <= r_words - 1'b1;
                end
                RSHIFT: begin
                    if (r_bitcnt == BCW'(DW)) begin
                        r_bitcnt <= '0;
                        if (r_words != '0) begin
                            r_a <= r_a + 1'b1;
                        end
                    end else begin
                        r_so     <= r_rd[0];
                        r_rd     <= r_rd >> 1;
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_next == IDLE) begin
                r_bitcnt <= '0;
            end
        end
    end

endmodule
